// File: rtl/oam_dma_if.sv
// Bus-side handshake and address/control signals of the sprite DMA engine.
// The tristate data bus is a separate module port so it can resolve against other drivers.
interface oam_dma_if #(
    parameter int ADDRESS_WIDTH = 16
);
    logic                     bus_request;
    logic                     bus_grant;
    logic [ADDRESS_WIDTH-1:0] bus_address;
    logic                     bus_cs;
    logic                     bus_we;

    modport master (
        output bus_request, bus_address, bus_cs, bus_we,
        input  bus_grant
    );

    modport slave (
        input  bus_request, bus_address, bus_cs, bus_we,
        output bus_grant
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: copies the 256 bytes of a source page to the OAM data port,
// one read/latch/write triple per byte, yielding the bus whenever the arbiter withdraws grant.
module oam_dma #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDRESS_WIDTH    = 16,
    parameter logic [ADDRESS_WIDTH-1:0] OAM_PORT_ADDRESS = ADDRESS_WIDTH'(16'h2004)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            page,
    output logic                  busy,
    output logic                  done,
    oam_dma_if.master             bus,
    inout  wire  [DATA_WIDTH-1:0] bus_data
);
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        LATCH,
        WRITE,
        DONE
    } state_t;

    state_t                  state;
    logic [7:0]              index;
    logic [7:0]              page_reg;
    logic [DATA_WIDTH-1:0]   latch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            index    <= '0;
            page_reg <= '0;
            latch    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    page_reg <= page;
                    index    <= '0;
                    state    <= REQ;
                end
                REQ:   if (bus.bus_grant) state <= READ;
                READ:  state <= LATCH;
                // Source memory returns data one cycle after the address, so sample at the end of LATCH.
                LATCH: begin
                    latch <= bus_data;
                    state <= WRITE;
                end
                WRITE: begin
                    if (index == 8'hFF) begin
                        state <= DONE;
                    end else begin
                        index <= index + 8'd1;
                        state <= bus.bus_grant ? READ : REQ;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode purely from registered state, so an async reset clears them immediately.
    logic rd_phase;
    assign rd_phase = (state == READ) || (state == LATCH);

    assign bus.bus_request = rd_phase || (state == REQ) || (state == WRITE);
    assign bus.bus_cs      = rd_phase || (state == WRITE);
    assign bus.bus_we      = (state == WRITE);
    assign bus.bus_address = rd_phase         ? ADDRESS_WIDTH'({page_reg, index}) :
                             (state == WRITE) ? OAM_PORT_ADDRESS : '0;
    assign bus_data        = (state == WRITE) ? latch : 'z;
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: full transfer, grant pause, ignored restart, async reset mid-byte.
module tb_oam_dma;
    localparam int DW = 8;
    localparam int AW = 16;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    page  = 8'h00;
    logic          grant = 1'b1;
    logic          busy, done;
    wire  [DW-1:0] bus_data;

    oam_dma_if #(.ADDRESS_WIDTH(AW)) bus ();
    assign bus.bus_grant = grant;

    oam_dma #(
        .DATA_WIDTH      (DW),
        .ADDRESS_WIDTH   (AW),
        .OAM_PORT_ADDRESS(16'h2004)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .page    (page),
        .busy    (busy),
        .done    (done),
        .bus     (bus),
        .bus_data(bus_data)
    );

    always #5 clk = ~clk;

    // Source RAM with one-cycle registered read; drives only on the second cycle of a read.
    logic [7:0] mem [0:65535];
    logic       rd_q;
    logic [7:0] ram_q;
    always @(posedge clk) begin
        rd_q  <= bus.bus_cs && !bus.bus_we;
        ram_q <= mem[bus.bus_address];
    end
    assign bus_data = (rd_q && bus.bus_cs && !bus.bus_we) ? ram_q : 'z;
    // Undriven bus reads as all ones, making any stray DMA drive visible.
    pullup pu_data (bus_data);

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // pause_at / restart_at / reset_at are byte indices, -1 disables; exp_done is the done cycle after t0.
    task automatic run_xfer(input logic [7:0] pg, input int pause_at, input int restart_at,
                            input int reset_at, input int exp_done);
        int n, wr, pause_left;
        bit prev_rd, fin;
        n = 0; wr = 0; pause_left = 0; prev_rd = 0; fin = 0;
        @(negedge clk);
        page  = pg;
        start = 1'b1;
        grant = 1'b1;
        @(negedge clk);
        start = 1'b0;
        page  = 8'h00;
        n = 1;
        chk("req_first", {bus.bus_request, bus.bus_cs, busy}, 3'b101);
        while (!fin && n < 1200) begin
            if (pause_left > 0) begin
                chk("pause_cs", bus.bus_cs, 1'b0);
                pause_left--;
                if (pause_left == 0) grant = 1'b1;
            end
            if (bus.bus_cs && !bus.bus_we && !prev_rd) begin
                chk("rd_addr", bus.bus_address, {pg, 8'(wr)});
                chk("rd_hiz", bus_data, 8'hFF);
                if (wr == restart_at) begin
                    start = 1'b1;
                    page  = 8'h03;
                end
            end else if (bus.bus_cs && !bus.bus_we && prev_rd) begin
                chk("latch_addr", bus.bus_address, {pg, 8'(wr)});
                if (wr == reset_at) begin
                    #2 reset = 1'b1;
                    #1;
                    chk("rst_async", {bus.bus_cs, bus.bus_request, busy, bus.bus_we, done}, 5'b0);
                    chk("rst_hiz", bus_data, 8'hFF);
                    chk("rst_addr", bus.bus_address, 16'h0000);
                    fin = 1;
                end
            end
            if (!fin && bus.bus_cs && bus.bus_we) begin
                chk("wr_addr", bus.bus_address, 16'h2004);
                chk("wr_data", bus_data, 8'(wr) ^ 8'hA5);
                if (wr == pause_at) begin
                    grant = 1'b0;
                    pause_left = 10;
                end
                wr++;
            end
            if (!fin && !bus.bus_cs) begin
                chk("nocs_hiz", bus_data, 8'hFF);
                chk("nocs_bus", {bus.bus_we, bus.bus_address}, 17'h0);
            end
            if (!fin && done) begin
                chk("done_cyc", n, exp_done);
                chk("done_bus", {bus.bus_request, bus.bus_cs, busy}, 3'b001);
                fin = 1;
            end
            prev_rd = bus.bus_cs && !bus.bus_we;
            if (!fin) begin
                @(negedge clk);
                n++;
                if (start) begin
                    start = 1'b0;
                    page  = 8'h00;
                end
            end
        end
        if (!fin) chk("timeout", 1'b0, 1'b1);
        if (reset_at >= 0) begin
            @(negedge clk);
            reset = 1'b0;
            chk("rst_writes", wr, reset_at);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                chk("post_rst", {busy, done, bus.bus_request, bus.bus_cs}, 4'b0);
            end
        end else begin
            chk("n_writes", wr, 256);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("after_done", {busy, done, bus.bus_request}, 3'b0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[{8'h02, 8'(i)}] = 8'(i) ^ 8'hA5;
            mem[{8'h03, 8'(i)}] = 8'(i) ^ 8'h3C;
        end
        #3;
        chk("rst_ctl", {busy, done, bus.bus_request, bus.bus_cs, bus.bus_we}, 5'b0);
        chk("rst_addr0", bus.bus_address, 16'h0000);
        chk("rst_data", bus_data, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_hold", {busy, bus.bus_request, bus.bus_cs}, 3'b0);
        end
        run_xfer(8'h02, -1, -1, -1, 770);
        run_xfer(8'h02,  5, -1, -1, 780);
        run_xfer(8'h02, -1, 100, -1, 770);
        run_xfer(8'h02, -1, -1, 40, -1);
        run_xfer(8'h02, -1, -1, -1, 770);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001: Parameter DATA_WIDTH, default 8, bus data width in bits.
REQ-002: Parameter ADDRESS_WIDTH, default 16, bus address width in bits.
REQ-003: Parameter OAM_PORT_ADDRESS, default 16'h2004, bus address receiving every DMA write.
REQ-004: clk  input  1  single clock; all state changes on rising edge.
REQ-005: reset  input  1  asynchronous, active-high reset.
REQ-006: start  input  1  one-cycle transfer request, sampled on the rising edge while IDLE.
REQ-007: page  input  8  source page; source byte i lives at {page, i}.
REQ-008: bus_grant  input  1  arbiter grant; when high, this block may drive the bus.
REQ-009: bus_request  output  1  high from the first cycle after start until the end of the transfer.
REQ-010: bus_address  output  ADDRESS_WIDTH  bus address.
REQ-011: bus_cs  output  1  bus chip select.
REQ-012: bus_we  output  1  bus write enable.
REQ-013: bus_data  inout  DATA_WIDTH  driven only in WRITE, high-Z otherwise.
REQ-014: busy  output  1  high whenever state is not IDLE.
REQ-015: done  output  1  one-cycle pulse at transfer completion.

Function
REQ-016: The block SHALL be a Moore FSM with states IDLE, REQ, READ, LATCH, WRITE and DONE; all outputs SHALL decode from registered state, index, page and latch only.
REQ-017: In IDLE, start=1 SHALL capture page into an internal page register, clear the 8-bit index to 0 and move to REQ.
REQ-018: In IDLE, start=0 SHALL keep the FSM in IDLE.
REQ-019: In REQ, bus_request SHALL be 1 and bus_cs 0; bus_grant=1 SHALL move the FSM to READ, otherwise it stays in REQ.
REQ-020: READ SHALL drive bus_address={page_reg, index}, bus_cs=1, bus_we=0, then move to LATCH.
REQ-021: LATCH SHALL hold READ's address, cs and we values, and SHALL capture bus_data into the data latch at the closing edge, then move to WRITE; this matches the bus's one-cycle registered read latency.
REQ-022: WRITE SHALL drive bus_address=OAM_PORT_ADDRESS, bus_cs=1, bus_we=1 and bus_data=latch.
REQ-023: At the end of WRITE, index=255 SHALL move the FSM to DONE.
REQ-024: At the end of WRITE, index<255 SHALL increment index, then move to READ if bus_grant=1, else to REQ (pause).
REQ-025: A paused transfer SHALL resume at the incremented index; it SHALL never repeat or skip a byte.
REQ-026: DONE SHALL assert done=1, bus_request=0 and bus_cs=0 for exactly one cycle, then move to IDLE.
REQ-027: bus_request SHALL be 1 in REQ, READ, LATCH and WRITE, and 0 in IDLE and DONE.
REQ-028: start asserted in any state other than IDLE SHALL be ignored, and page_reg SHALL not change.
REQ-029: bus_grant SHALL be sampled only in REQ and at the end of WRITE; a grant drop during READ or LATCH SHALL not abort the byte.
REQ-030: Index arithmetic SHALL be 8-bit; the 255 to 0 wrap SHALL never occur inside a transfer.
REQ-031: With bus_grant held at 1, the transfer SHALL take exactly 768 bus cycles (3 per byte), plus 1 REQ cycle and 1 DONE cycle.
REQ-032: In every state other than READ, LATCH and WRITE, bus_address SHALL be 0, bus_cs 0 and bus_we 0.

Reset
REQ-033: On reset=1, the block SHALL immediately, without waiting for clk, enter IDLE and clear index, page_reg and latch to 0.
REQ-034: During reset, bus_request, bus_cs, bus_we, busy and done SHALL be 0, bus_address SHALL be 0 and bus_data SHALL be high-Z.
REQ-035: Reset asserted mid-transfer SHALL abandon the transfer with no done pulse; after reset is released the block SHALL wait for a new start.

Verification
REQ-036: RAM page 0x02 preloaded with bytes i^0xA5, start with page=0x02 at edge t0, grant tied to 1 -> REQ in cycle t0+1; writes to 0x2004 carry 0xA5, 0xA4, ... in order; done pulses in cycle t0+770; 256 writes in total.
REQ-037: Grant dropped for 10 cycles after byte 5's WRITE -> bus_cs stays 0 during the pause; byte 6 (page offset 0x06) is the first write after the grant returns; total is still 256 writes.
REQ-038: start pulsed again with page=0x03 during byte 100 -> ignored; all reads stay at 0x02xx; exactly one done pulse.
REQ-039: Reset asserted asynchronously during a LATCH state -> bus_cs, bus_request and busy fall before the next clk edge; bus_data is high-Z; no done pulse follows.
REQ-040: Check bus_data during READ and LATCH and during IDLE -> high-Z on every bit; driven only while bus_we=1.
